// File: rtl/ahb2axi_pkg.sv
// ahb2axi_pkg: shared types and constants for the AHB-Lite to AXI4-Lite bridge.
//   state_t          - bridge FSM states
//   HTRANS_*         - AHB transfer type encodings
//   HSIZE_*          - AHB transfer size encodings
//   RESP_*           - AXI response encodings
//   hsize_to_arsize  - maps AHB HSIZE onto AXI ARSIZE (11 folds to word)
package ahb2axi_pkg;

    typedef enum logic [3:0] {
        s_reset,
        s_idle,
        s_wdata,
        s_waxi,
        s_wresp,
        s_raxi,
        s_rresp,
        s_err1,
        s_err2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HSIZE_BYTE = 2'b00;
    localparam logic [1:0] HSIZE_HALF = 2'b01;
    localparam logic [1:0] HSIZE_WORD = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [2:0] hsize_to_arsize(input logic [1:0] hsize);
        return (hsize == 2'b11) ? 3'b010 : {1'b0, hsize};
    endfunction

endpackage

// File: rtl/ahb2axi_if.sv
// ahb2axi_if: bundles the AHB-Lite slave port and the AXI4-Lite master port
// of the bridge.
//   modport slave  - the bridge's view: AHB requests in, AHB response out,
//                    AXI requests out, AXI responses in.
//   modport master - the surrounding system's view (AHB interconnect plus
//                    downstream AXI4-Lite slave), all directions reversed.
interface ahb2axi_if;

    // AHB-Lite
    logic        ahb_hsel;
    logic [31:0] ahb_haddr;
    logic [1:0]  ahb_htrans;
    logic [1:0]  ahb_hsize;
    logic        ahb_hwrite;
    logic [31:0] ahb_hwdata;
    logic        ahb_hready;
    logic        ahb_hreadyout;
    logic        ahb_hresp;
    logic [31:0] ahb_hrdata;

    // AXI4-Lite write channels
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    // AXI4-Lite read channels
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arsize;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    modport slave (
        input  ahb_hsel, ahb_haddr, ahb_htrans, ahb_hsize, ahb_hwrite,
               ahb_hwdata, ahb_hready,
        output ahb_hreadyout, ahb_hresp, ahb_hrdata,
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arsize, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport master (
        output ahb_hsel, ahb_haddr, ahb_htrans, ahb_hsize, ahb_hwrite,
               ahb_hwdata, ahb_hready,
        input  ahb_hreadyout, ahb_hresp, ahb_hrdata,
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arsize, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

endinterface

// File: rtl/ahb2axi_strb.sv
// ahb2axi_strb: combinational write-strobe decode.
//   hsize   in 2 - captured AHB transfer size
//   addr_lo in 2 - captured address bits [1:0]
//   wstrb   out 4 - AXI byte-lane strobes
module ahb2axi_strb (
    input  logic [1:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);
    import ahb2axi_pkg::*;

    always_comb begin
        wstrb = 4'b1111;
        case (hsize)
            HSIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            HSIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            default:    wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb2axi.sv
// ahb2axi: AHB-Lite slave to AXI4-Lite master bridge. Each captured AHB
// transfer becomes one AXI4-Lite read or write; the AHB data phase is held
// with ahb_hreadyout until the AXI response arrives, and SLVERR/DECERR turn
// into the two-cycle AHB ERROR response.
//   P_ALIGN_ADDR - 1 forces AXI address bits [1:0] to zero
//   clk, reset   - single clock, synchronous active-high reset
//   bus          - ahb2axi_if.slave (AHB-Lite slave + AXI4-Lite master)
// Every output is a flop; nothing combinational runs from inputs to outputs.
module ahb2axi #(
    parameter bit P_ALIGN_ADDR = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    ahb2axi_if.slave  bus
);
    import ahb2axi_pkg::*;

    state_t      state_q, state_d;
    logic        can_capture, capture;
    logic        aw_done, w_done;
    logic [31:0] addr_in;
    logic [3:0]  strb;

    logic [1:0]  haddr_lo_q, haddr_lo_d;
    logic [1:0]  hsize_q, hsize_d;
    logic        hwrite_q, hwrite_d;

    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;

    // A new address phase is only accepted while this slave shows ready.
    assign can_capture = (state_q == s_idle) || (state_q == s_err2);
    assign capture     = can_capture && bus.ahb_hsel && bus.ahb_hready && bus.ahb_htrans[1];
    assign addr_in     = P_ALIGN_ADDR ? {bus.ahb_haddr[31:2], 2'b00} : bus.ahb_haddr;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !awvalid_q || bus.axi_awready;
    assign w_done  = !wvalid_q  || bus.axi_wready;

    ahb2axi_strb u_strb (
        .hsize   (hsize_q),
        .addr_lo (haddr_lo_q),
        .wstrb   (strb)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            s_reset: state_d = s_idle;
            s_idle, s_err2: begin
                if (capture)
                    state_d = bus.ahb_hwrite ? s_wdata : s_raxi;
                else
                    state_d = s_idle;
            end
            s_wdata: state_d = s_waxi;
            s_waxi:  if (aw_done && w_done) state_d = s_wresp;
            s_wresp: if (bus.axi_bvalid) state_d = bus.axi_bresp[1] ? s_err1 : s_idle;
            s_raxi:  if (bus.axi_arready) state_d = s_rresp;
            s_rresp: if (bus.axi_rvalid) state_d = bus.axi_rresp[1] ? s_err1 : s_idle;
            s_err1:  state_d = s_err2;
            default: state_d = s_idle;
        endcase
    end

    // Output logic: next values of the output flops, derived from state_d so
    // that each registered output lines up with the state it belongs to.
    always_comb begin
        haddr_lo_d  = haddr_lo_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        hrdata_d    = hrdata_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        arsize_d    = arsize_q;

        hreadyout_d = (state_d == s_idle) || (state_d == s_err2);
        hresp_d     = (state_d == s_err1) || (state_d == s_err2);
        bready_d    = (state_d == s_wresp);
        arvalid_d   = (state_d == s_raxi);
        rready_d    = (state_d == s_rresp);

        // AW and W rise together and each falls on its own handshake.
        case (state_q)
            s_wdata: begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end
            s_waxi: begin
                awvalid_d = awvalid_q && !bus.axi_awready;
                wvalid_d  = wvalid_q  && !bus.axi_wready;
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase

        if (capture) begin
            haddr_lo_d = bus.ahb_haddr[1:0];
            hsize_d    = bus.ahb_hsize;
            hwrite_d   = bus.ahb_hwrite;
            if (bus.ahb_hwrite) begin
                awaddr_d = addr_in;
            end else begin
                araddr_d = addr_in;
                arsize_d = hsize_to_arsize(bus.ahb_hsize);
            end
        end

        // Write data only becomes valid on the AHB bus in the data phase.
        if (state_q == s_wdata) begin
            wdata_d = bus.ahb_hwdata;
            wstrb_d = strb;
        end

        if ((state_q == s_rresp) && !hwrite_q && bus.axi_rvalid)
            hrdata_d = bus.axi_rdata;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= s_reset;
            haddr_lo_q  <= 2'b00;
            hsize_q     <= 2'b00;
            hwrite_q    <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arsize_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_lo_q  <= haddr_lo_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arsize_q    <= arsize_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign bus.ahb_hreadyout = hreadyout_q;
    assign bus.ahb_hresp     = hresp_q;
    assign bus.ahb_hrdata    = hrdata_q;
    assign bus.axi_awaddr    = awaddr_q;
    assign bus.axi_awvalid   = awvalid_q;
    assign bus.axi_wdata     = wdata_q;
    assign bus.axi_wstrb     = wstrb_q;
    assign bus.axi_wvalid    = wvalid_q;
    assign bus.axi_bready    = bready_q;
    assign bus.axi_araddr    = araddr_q;
    assign bus.axi_arsize    = arsize_q;
    assign bus.axi_arvalid   = arvalid_q;
    assign bus.axi_rready    = rready_q;

endmodule

// File: tb/tb_ahb2axi.sv
// tb_ahb2axi: directed bench for ahb2axi. Inputs change and outputs are
// sampled on the falling clock edge; the bridge acts on the rising edge.
module tb_ahb2axi;
    import ahb2axi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   count_en = 1'b0;
    int   aw_hs = 0;
    int   w_hs  = 0;

    ahb2axi_if bus ();

    ahb2axi #(.P_ALIGN_ADDR(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (count_en) begin
            if (bus.axi_awvalid && bus.axi_awready) aw_hs <= aw_hs + 1;
            if (bus.axi_wvalid && bus.axi_wready)   w_hs  <= w_hs + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic ahb_addr(input logic [31:0] a, input logic [1:0] sz, input logic wr);
        bus.ahb_hsel   = 1'b1;
        bus.ahb_htrans = HTRANS_NONSEQ;
        bus.ahb_haddr  = a;
        bus.ahb_hsize  = sz;
        bus.ahb_hwrite = wr;
    endtask

    task automatic ahb_idle();
        bus.ahb_hsel   = 1'b0;
        bus.ahb_htrans = HTRANS_IDLE;
        bus.ahb_haddr  = 32'h0;
        bus.ahb_hwrite = 1'b0;
    endtask

    // Write against a zero-wait AXI slave: address phase at the current
    // falling edge, then four data-phase cycles.
    task automatic zw_write(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input logic [3:0] exp_strb);
        bus.axi_awready = 1'b1;
        bus.axi_wready  = 1'b1;
        ahb_addr(a, sz, 1'b1);
        step();
        chk({tag, "_c1_hreadyout"}, 32'(bus.ahb_hreadyout), 32'd0);
        chk({tag, "_c1_awvalid"}, 32'(bus.axi_awvalid), 32'd0);
        ahb_idle();
        bus.ahb_hwdata = d;
        step();
        chk({tag, "_c2_awvalid"}, 32'(bus.axi_awvalid), 32'd1);
        chk({tag, "_c2_wvalid"}, 32'(bus.axi_wvalid), 32'd1);
        chk({tag, "_awaddr"}, bus.axi_awaddr, a);
        chk({tag, "_wdata"}, bus.axi_wdata, d);
        chk({tag, "_wstrb"}, 32'(bus.axi_wstrb), 32'(exp_strb));
        bus.ahb_hwdata = 32'h0;
        step();
        chk({tag, "_c3_bready"}, 32'(bus.axi_bready), 32'd1);
        chk({tag, "_c3_awvalid"}, 32'(bus.axi_awvalid), 32'd0);
        chk({tag, "_c3_wvalid"}, 32'(bus.axi_wvalid), 32'd0);
        chk({tag, "_c3_hreadyout"}, 32'(bus.ahb_hreadyout), 32'd0);
        bus.axi_bvalid = 1'b1;
        bus.axi_bresp  = RESP_OKAY;
        step();
        chk({tag, "_c4_hreadyout"}, 32'(bus.ahb_hreadyout), 32'd1);
        chk({tag, "_c4_hresp"}, 32'(bus.ahb_hresp), 32'd0);
        chk({tag, "_c4_bready"}, 32'(bus.axi_bready), 32'd0);
        bus.axi_bvalid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.ahb_hsel    = 1'b0;
        bus.ahb_haddr   = 32'h0;
        bus.ahb_htrans  = HTRANS_IDLE;
        bus.ahb_hsize   = HSIZE_WORD;
        bus.ahb_hwrite  = 1'b0;
        bus.ahb_hwdata  = 32'h0;
        bus.ahb_hready  = 1'b1;
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.axi_bresp   = RESP_OKAY;
        bus.axi_bvalid  = 1'b0;
        bus.axi_arready = 1'b0;
        bus.axi_rdata   = 32'h0;
        bus.axi_rresp   = RESP_OKAY;
        bus.axi_rvalid  = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        chk("rst_hresp", 32'(bus.ahb_hresp), 32'd0);
        chk("rst_hrdata", bus.ahb_hrdata, 32'h0);
        chk("rst_valids", {28'h0, bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, 1'b0}, 32'h0);
        chk("rst_readys", {30'h0, bus.axi_bready, bus.axi_rready}, 32'h0);
        chk("rst_awaddr", bus.axi_awaddr, 32'h0);
        chk("rst_araddr", bus.axi_araddr, 32'h0);
        chk("rst_wdata", bus.axi_wdata, 32'h0);
        chk("rst_wstrb", 32'(bus.axi_wstrb), 32'h0);
        reset = 1'b0;
        step();
        chk("idle_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);

        // Zero-wait writes: word, byte, half-word
        zw_write("wword", 32'h1000_0004, HSIZE_WORD, 32'hDEAD_BEEF, 4'b1111);
        zw_write("wbyte", 32'h0000_0003, HSIZE_BYTE, 32'hAB00_0000, 4'b1000);
        zw_write("whalf", 32'h0000_0002, HSIZE_HALF, 32'h5566_0000, 4'b1100);

        // Read with AR held off for 3 cycles and R delayed 2 cycles
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.axi_arready = 1'b0;
        ahb_addr(32'h2000_0000, HSIZE_WORD, 1'b0);
        step();
        ahb_idle();
        chk("rd_c1_arvalid", 32'(bus.axi_arvalid), 32'd1);
        chk("rd_araddr", bus.axi_araddr, 32'h2000_0000);
        chk("rd_arsize", 32'(bus.axi_arsize), 32'd2);
        chk("rd_c1_hreadyout", 32'(bus.ahb_hreadyout), 32'd0);
        step();
        chk("rd_c2_arvalid", 32'(bus.axi_arvalid), 32'd1);
        step();
        chk("rd_c3_arvalid", 32'(bus.axi_arvalid), 32'd1);
        chk("rd_c3_araddr", bus.axi_araddr, 32'h2000_0000);
        step();
        chk("rd_c4_arvalid", 32'(bus.axi_arvalid), 32'd1);
        chk("rd_c4_rready", 32'(bus.axi_rready), 32'd0);
        bus.axi_arready = 1'b1;
        step();
        bus.axi_arready = 1'b0;
        chk("rd_c5_arvalid", 32'(bus.axi_arvalid), 32'd0);
        chk("rd_c5_rready", 32'(bus.axi_rready), 32'd1);
        step();
        chk("rd_c6_hreadyout", 32'(bus.ahb_hreadyout), 32'd0);
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = 32'h1234_5678;
        bus.axi_rresp  = RESP_OKAY;
        step();
        bus.axi_rvalid = 1'b0;
        bus.axi_rdata  = 32'hFFFF_FFFF;
        chk("rd_done_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        chk("rd_done_hrdata", bus.ahb_hrdata, 32'h1234_5678);
        chk("rd_done_hresp", 32'(bus.ahb_hresp), 32'd0);
        chk("rd_done_rready", 32'(bus.axi_rready), 32'd0);
        step();
        chk("rd_hold_hrdata", bus.ahb_hrdata, 32'h1234_5678);

        // Write answered with SLVERR, master goes IDLE in the second cycle
        bus.axi_awready = 1'b1;
        bus.axi_wready  = 1'b1;
        ahb_addr(32'h3000_0000, HSIZE_WORD, 1'b1);
        step();
        ahb_idle();
        bus.ahb_hwdata = 32'h1111_1111;
        step();
        step();
        bus.axi_bvalid = 1'b1;
        bus.axi_bresp  = RESP_SLVERR;
        step();
        bus.axi_bvalid = 1'b0;
        bus.axi_bresp  = RESP_OKAY;
        chk("werr_c1_hresp", 32'(bus.ahb_hresp), 32'd1);
        chk("werr_c1_hreadyout", 32'(bus.ahb_hreadyout), 32'd0);
        step();
        chk("werr_c2_hresp", 32'(bus.ahb_hresp), 32'd1);
        chk("werr_c2_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        step();
        chk("werr_after_hresp", 32'(bus.ahb_hresp), 32'd0);
        chk("werr_after_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        chk("werr_after_valids", {29'h0, bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid}, 32'h0);

        // Read answered with DECERR, then a read pipelined into the second ERROR cycle
        bus.axi_arready = 1'b1;
        ahb_addr(32'h4000_0000, HSIZE_WORD, 1'b0);
        step();
        ahb_idle();
        chk("rerr_arvalid", 32'(bus.axi_arvalid), 32'd1);
        step();
        bus.axi_arready = 1'b0;
        bus.axi_rvalid  = 1'b1;
        bus.axi_rdata   = 32'hCAFE_F00D;
        bus.axi_rresp   = RESP_DECERR;
        step();
        bus.axi_rvalid = 1'b0;
        bus.axi_rresp  = RESP_OKAY;
        chk("rerr_c1_hresp", 32'(bus.ahb_hresp), 32'd1);
        chk("rerr_c1_hreadyout", 32'(bus.ahb_hreadyout), 32'd0);
        step();
        chk("rerr_c2_hresp", 32'(bus.ahb_hresp), 32'd1);
        chk("rerr_c2_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        ahb_addr(32'h4000_0010, HSIZE_HALF, 1'b0);
        step();
        ahb_idle();
        chk("b2b_arvalid", 32'(bus.axi_arvalid), 32'd1);
        chk("b2b_araddr", bus.axi_araddr, 32'h4000_0010);
        chk("b2b_arsize", 32'(bus.axi_arsize), 32'd1);
        chk("b2b_hresp", 32'(bus.ahb_hresp), 32'd0);
        chk("b2b_hreadyout", 32'(bus.ahb_hreadyout), 32'd0);
        bus.axi_arready = 1'b1;
        step();
        bus.axi_arready = 1'b0;
        bus.axi_rvalid  = 1'b1;
        bus.axi_rdata   = 32'h0BAD_CAFE;
        bus.axi_rresp   = RESP_EXOKAY;
        step();
        bus.axi_rvalid = 1'b0;
        bus.axi_rresp  = RESP_OKAY;
        chk("exokay_hresp", 32'(bus.ahb_hresp), 32'd0);
        chk("exokay_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        chk("exokay_hrdata", bus.ahb_hrdata, 32'h0BAD_CAFE);

        // Reset while AW/W are pending
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        ahb_addr(32'h5000_0000, HSIZE_WORD, 1'b1);
        step();
        ahb_idle();
        bus.ahb_hwdata = 32'h2222_2222;
        step();
        chk("rmid_awvalid_before", 32'(bus.axi_awvalid), 32'd1);
        reset = 1'b1;
        step();
        chk("rmid_valids", {29'h0, bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid}, 32'h0);
        chk("rmid_readys", {30'h0, bus.axi_bready, bus.axi_rready}, 32'h0);
        chk("rmid_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        chk("rmid_awaddr", bus.axi_awaddr, 32'h0);
        reset = 1'b0;
        step();

        // W accepted before AW
        count_en = 1'b1;
        ahb_addr(32'h6000_0008, HSIZE_WORD, 1'b1);
        step();
        ahb_idle();
        bus.ahb_hwdata = 32'h1357_9BDF;
        step();
        chk("wfirst_c2_valids", {30'h0, bus.axi_awvalid, bus.axi_wvalid}, 32'h3);
        bus.axi_wready = 1'b1;
        step();
        chk("wfirst_c3_awvalid", 32'(bus.axi_awvalid), 32'd1);
        chk("wfirst_c3_wvalid", 32'(bus.axi_wvalid), 32'd0);
        chk("wfirst_c3_bready", 32'(bus.axi_bready), 32'd0);
        step();
        chk("wfirst_c4_awvalid", 32'(bus.axi_awvalid), 32'd1);
        chk("wfirst_c4_wdata", bus.axi_wdata, 32'h1357_9BDF);
        bus.axi_awready = 1'b1;
        step();
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        chk("wfirst_c5_valids", {30'h0, bus.axi_awvalid, bus.axi_wvalid}, 32'h0);
        chk("wfirst_c5_bready", 32'(bus.axi_bready), 32'd1);
        bus.axi_bvalid = 1'b1;
        bus.axi_bresp  = RESP_OKAY;
        step();
        bus.axi_bvalid = 1'b0;
        count_en = 1'b0;
        chk("wfirst_done_hreadyout", 32'(bus.ahb_hreadyout), 32'd1);
        chk("wfirst_done_hresp", 32'(bus.ahb_hresp), 32'd0);
        chk("wfirst_aw_handshakes", 32'(aw_hs), 32'd1);
        chk("wfirst_w_handshakes", 32'(w_hs), 32'd1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
